// File: rtl/prbs8_checker.sv
// prbs8_checker: self-synchronising checker for the 8-bit XNOR LFSR stream
// (taps 7,3,2,1). It fills an 8-bit history from the received stream and
// counts consecutive correct predictions until it locks. Once locked it
// free-runs its own history and counts mismatches. Too many mismatches in
// one window drop it back to acquisition.
// Optional feature macro: PRBS8_CHECKER_BIT_CNT_EN. When defined, it adds
// bit_cnt_o, a saturating count of the bits accepted while locked.
module prbs8_checker #(
    parameter int LOCK_CNT   = 16,
    parameter int ERR_WIN    = 64,
    parameter int ERR_THRESH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic                 data_i,
    input  logic                 clear_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o
`ifdef PRBS8_CHECKER_BIT_CNT_EN
    ,
    output logic [31:0]          bit_cnt_o
`endif
);

    localparam int WIN_W = $clog2(ERR_WIN + 1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [7:0]           hist_q, hist_d;
    logic [3:0]           fill_q, fill_d;
    logic [7:0]           match_q, match_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [WIN_W-1:0]     werr_q, werr_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] errcnt_q, errcnt_d;
`ifdef PRBS8_CHECKER_BIT_CNT_EN
    logic [31:0]          bitcnt_q, bitcnt_d;
`endif

    logic                 miss;
    logic                 bit_hit;
    logic                 e_bit;
    logic [WIN_W-1:0]     win_inc;
    logic [WIN_W-1:0]     werr_inc;

    // Next stream bit implied by the history; h[0] is the newest bit.
    function automatic logic predict(input logic [7:0] h);
        return ~(h[7] ^ h[3] ^ h[2] ^ h[1]);
    endfunction

    // State register: every piece of state restarts cleanly on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= SEARCH;
            hist_q   <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            win_q    <= '0;
            werr_q   <= '0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
`ifdef PRBS8_CHECKER_BIT_CNT_EN
            bitcnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            win_q    <= win_d;
            werr_q   <= werr_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
`ifdef PRBS8_CHECKER_BIT_CNT_EN
            bitcnt_q <= bitcnt_d;
`endif
        end
    end

    // Next-state logic: acquisition, free-running prediction and loss-of-lock window.
    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        match_d  = match_q;
        win_d    = win_q;
        werr_d   = werr_q;
        err_d    = 1'b0;
        miss     = 1'b0;
        bit_hit  = 1'b0;
        e_bit    = predict(hist_q);
        win_inc  = win_q + WIN_W'(1);
        werr_inc = werr_q;

        if (valid_i) begin
            if (state_q == SEARCH) begin
                hist_d = {hist_q[6:0], data_i};
                if (fill_q != 4'd8) begin
                    fill_d = fill_q + 4'd1;
                end else if ((data_i == e_bit) && (hist_q != 8'hFF)) begin
                    // All-ones is the XNOR lockup state and never counts toward lock.
                    match_d = match_q + 8'd1;
                    if (match_d == 8'(LOCK_CNT)) begin
                        state_d = LOCKED;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end
                end else begin
                    match_d = '0;
                end
            end else begin
                // Received bits never enter the history, so one flipped bit costs one error.
                hist_d   = {hist_q[6:0], e_bit};
                miss     = (data_i != e_bit);
                bit_hit  = 1'b1;
                err_d    = miss;
                werr_inc = werr_q + WIN_W'(miss);
                if (werr_inc == WIN_W'(ERR_THRESH)) begin
                    state_d = SEARCH;
                    fill_d  = '0;
                    match_d = '0;
                    win_d   = '0;
                    werr_d  = '0;
                end else if (win_inc == WIN_W'(ERR_WIN)) begin
                    win_d  = '0;
                    werr_d = '0;
                end else begin
                    win_d  = win_inc;
                    werr_d = werr_inc;
                end
            end
        end

        // A clear that coincides with an error leaves that error counted.
        if (clear_i) begin
            errcnt_d = CNT_WIDTH'(miss);
        end else if (miss && (errcnt_q != {CNT_WIDTH{1'b1}})) begin
            errcnt_d = errcnt_q + CNT_WIDTH'(1);
        end else begin
            errcnt_d = errcnt_q;
        end

`ifdef PRBS8_CHECKER_BIT_CNT_EN
        if (clear_i) begin
            bitcnt_d = 32'(bit_hit);
        end else if (bit_hit && (bitcnt_q != 32'hFFFF_FFFF)) begin
            bitcnt_d = bitcnt_q + 32'd1;
        end else begin
            bitcnt_d = bitcnt_q;
        end
`endif
    end

    // Output decode: all outputs come straight from registers.
    always_comb begin
        locked_o  = (state_q == LOCKED);
        err_o     = err_q;
        err_cnt_o = errcnt_q;
`ifdef PRBS8_CHECKER_BIT_CNT_EN
        bit_cnt_o = bitcnt_q;
`endif
    end

endmodule

// File: tb/tb_prbs8_checker.sv
// Bench for prbs8_checker: directed phases plus a random phase. The
// reference model tracks the checker's behaviour with queues and integers.
// A second instance with a 2-bit error counter covers saturation.
module tb_prbs8_checker;

    localparam int LOCK_CNT   = 16;
    localparam int ERR_WIN    = 64;
    localparam int ERR_THRESH = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        data_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        locked_o, err_o;
    logic [15:0] err_cnt_o;
    logic        locked_s, err_s;
    logic [1:0]  cnt_s;
`ifdef PRBS8_CHECKER_BIT_CNT_EN
    logic [31:0] bit_cnt_o, bit_cnt_s;
`endif

    always #5 clk = ~clk;

    prbs8_checker #(.LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN), .ERR_THRESH(ERR_THRESH), .CNT_WIDTH(16)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i), .clear_i(clear_i),
        .locked_o(locked_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
`ifdef PRBS8_CHECKER_BIT_CNT_EN
        , .bit_cnt_o(bit_cnt_o)
`endif
    );

    prbs8_checker #(.LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN), .ERR_THRESH(ERR_THRESH), .CNT_WIDTH(2)) u_sat (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i), .clear_i(clear_i),
        .locked_o(locked_s), .err_o(err_s), .err_cnt_o(cnt_s)
`ifdef PRBS8_CHECKER_BIT_CNT_EN
        , .bit_cnt_o(bit_cnt_s)
`endif
    );

    int n_vec = 0;
    int n_mis = 0;
    bit cmp_en = 1'b0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Generator: the stream source, kept as the last 8 emitted bits (oldest first).
    bit gq[$];
    task automatic gen_seed0();
        gq = {};
        for (int i = 0; i < 8; i++) gq.push_back(1'b0);
    endtask
    function automatic bit gen_next();
        bit b;
        b = !(gq[0] ^ gq[4] ^ gq[5] ^ gq[6]);
        gq.push_back(b);
        void'(gq.pop_front());
        return b;
    endfunction

    // Reference model, updated at each rising edge from the applied inputs.
    bit     mq[$];
    bit     m_locked, m_err, m_mis, m_was_locked, m_e;
    int     m_fill, m_match, m_win, m_werr;
    longint m_errs, m_bits;

    function automatic bit m_pred();
        return !(mq[0] ^ mq[4] ^ mq[5] ^ mq[6]);
    endfunction
    function automatic bit m_all_ones();
        int s = 0;
        foreach (mq[i]) s += int'(mq[i]);
        return s == 8;
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            mq = {};
            for (int i = 0; i < 8; i++) mq.push_back(1'b0);
            m_locked = 0; m_err = 0; m_fill = 0; m_match = 0;
            m_win = 0; m_werr = 0; m_errs = 0; m_bits = 0;
        end else begin
            m_mis = 0;
            m_was_locked = m_locked;
            if (valid_i) begin
                if (!m_locked) begin
                    if (m_fill < 8) m_fill++;
                    else if (data_i == m_pred() && !m_all_ones()) m_match++;
                    else m_match = 0;
                    mq.push_back(data_i); void'(mq.pop_front());
                    if (m_match == LOCK_CNT) begin
                        m_locked = 1; m_match = 0; m_win = 0; m_werr = 0;
                    end
                end else begin
                    m_e = m_pred();
                    mq.push_back(m_e); void'(mq.pop_front());
                    m_mis = (data_i != m_e);
                    m_bits++;
                    m_win++;
                    if (m_mis) m_werr++;
                    if (m_werr == ERR_THRESH) begin
                        m_locked = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
                    end else if (m_win == ERR_WIN) begin
                        m_win = 0; m_werr = 0;
                    end
                end
            end
            m_err = m_mis;
            if (clear_i) begin
                m_errs = m_mis ? 1 : 0;
                m_bits = (valid_i && m_was_locked) ? 1 : 0;
            end else if (m_mis) begin
                m_errs++;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("locked", 64'(locked_o), 64'(m_locked));
            cmp("err_o", 64'(err_o), 64'(m_err));
            cmp("err_cnt", 64'(err_cnt_o), (m_errs > 65535) ? 64'd65535 : 64'(m_errs));
            cmp("sat_locked", 64'(locked_s), 64'(m_locked));
            cmp("sat_err_o", 64'(err_s), 64'(m_err));
            cmp("sat_cnt", 64'(cnt_s), (m_errs > 3) ? 64'd3 : 64'(m_errs));
`ifdef PRBS8_CHECKER_BIT_CNT_EN
            cmp("bit_cnt", 64'(bit_cnt_o), (m_bits > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(m_bits));
`endif
        end
    end

    task automatic drive(input bit r, input bit v, input bit d, input bit c);
        @(negedge clk);
        rst_i = r; valid_i = v; data_i = d; clear_i = c;
    endtask
    task automatic settle();
        drive(0, 0, 0, 0);
    endtask
    task automatic do_reset();
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        gen_seed0();
    endtask
    task automatic send_gen(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) drive(0, 0, 1'($urandom_range(0, 1)), 0);
            drive(0, 1, gen_next(), 0);
        end
    endtask
    task automatic send_flip(input bit clr);
        drive(0, 1, !gen_next(), clr);
    endtask

    int pulses;
    bit r, v, f, c, d;

    initial begin
        // Reset state
        do_reset();
        settle();
        cmp_en = 1'b1;
        cmp("rst_locked", 64'(locked_o), 64'd0);
        cmp("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        cmp("rst_err_o", 64'(err_o), 64'd0);

        // Acquire: lock exactly after accepted bit 24
        send_gen(23, 0);
        settle();
        cmp("acq_23_unlocked", 64'(locked_o), 64'd0);
        send_gen(1, 0);
        settle();
        cmp("acq_24_locked", 64'(locked_o), 64'd1);
        cmp("acq_err_cnt", 64'(err_cnt_o), 64'd0);

        // Single error
        send_gen(10, 0);
        send_flip(0);
        settle();
        cmp("single_err_o", 64'(err_o), 64'd1);
        cmp("single_cnt", 64'(err_cnt_o), 64'd1);
        cmp("single_locked", 64'(locked_o), 64'd1);
        settle();
        cmp("single_err_low", 64'(err_o), 64'd0);
        send_gen(100, 0);
        settle();
        cmp("single_after100", 64'(err_cnt_o), 64'd1);

        // Loss of lock after 4 errors in one window, then re-lock
        drive(0, 1, gen_next(), 1);
        settle();
        cmp("clear_cnt", 64'(err_cnt_o), 64'd0);
        for (int i = 0; i < 3; i++) send_flip(0);
        settle();
        cmp("lol_3_locked", 64'(locked_o), 64'd1);
        send_flip(0);
        settle();
        cmp("lol_4_unlocked", 64'(locked_o), 64'd0);
        cmp("lol_cnt", 64'(err_cnt_o), 64'd4);
        cmp("lol_sat_cnt", 64'(cnt_s), 64'd3);
        send_gen(23, 0);
        settle();
        cmp("relock_23", 64'(locked_o), 64'd0);
        send_gen(1, 0);
        settle();
        cmp("relock_24", 64'(locked_o), 64'd1);

        // Lockup guard: all-ones never locks
        do_reset();
        for (int i = 0; i < 200; i++) drive(0, 1, 1'b1, 0);
        settle();
        cmp("ones_unlocked", 64'(locked_o), 64'd0);
        send_gen(24, 0);
        settle();
        cmp("ones_then_lock", 64'(locked_o), 64'd1);

        // Clear with valid gaps and a coincident error
        do_reset();
        send_gen(23, 1);
        settle();
        cmp("gap_23_unlocked", 64'(locked_o), 64'd0);
        send_gen(1, 1);
        settle();
        cmp("gap_24_locked", 64'(locked_o), 64'd1);
        send_gen(5, 1);
        send_flip(0);
        send_flip(0);
        send_gen(3, 1);
        send_flip(1);
        settle();
        cmp("clr_err_cnt", 64'(err_cnt_o), 64'd1);
        cmp("clr_sat_cnt", 64'(cnt_s), 64'd1);
        cmp("clr_err_o", 64'(err_o), 64'd1);
        cmp("clr_locked", 64'(locked_o), 64'd1);
`ifdef PRBS8_CHECKER_BIT_CNT_EN
        cmp("clr_bit_cnt", 64'(bit_cnt_o), 64'd1);
`endif

        // Saturation: one error per 64-bit window, five windows
        do_reset();
        send_gen(24, 0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            send_flip(0);
            settle();
            if (err_s) pulses++;
            send_gen(63, 0);
        end
        settle();
        cmp("sat_hold3", 64'(cnt_s), 64'd3);
        cmp("sat_still_locked", 64'(locked_s), 64'd1);
        cmp("sat_pulses", 64'(pulses), 64'd5);
        cmp("sat_wide_cnt", 64'(err_cnt_o), 64'd5);

        // Random traffic: gaps, sparse errors, clears and rare resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 999) == 0);
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 99) == 0);
            d = v ? (gen_next() ^ f) : 1'($urandom_range(0, 1));
            drive(r, v, d, c);
        end
        settle();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
